// File: rtl/parity_stream.sv
// parity_stream: streaming per-word and per-frame parity generator/checker.
// One output register slot with a full-throughput valid/ready handshake.
// A two-state FSM tracks whether a frame is open. While a frame is open the
// parity mode and the running parity are held. The frame parity check at the
// last beat feeds a saturating error counter.
module parity_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             odd_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_par,
    input  logic             err_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             out_last,
    output logic             frame_par,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FRAME = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic             r_mode;
    logic             r_acc;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_par;
    logic             r_out_last;
    logic             r_frame_par;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic w_accept;
    logic w_first;
    logic w_wp;
    logic w_mode;
    logic w_acc_nxt;
    logic w_fpar;
    logic w_err;
    logic w_inc;

    // The slot can take a new beat when it is empty or is draining this cycle.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    // The first beat of a frame samples the live mode and restarts the accumulator.
    assign w_first   = (r_state == S_IDLE);
    assign w_wp      = ^in_data;
    assign w_mode    = w_first ? odd_mode : r_mode;
    assign w_acc_nxt = w_first ? w_wp : (r_acc ^ w_wp);
    assign w_fpar    = w_acc_nxt ^ w_mode;
    assign w_err     = in_last && (in_par != w_fpar);
    assign w_inc     = w_accept && w_err;

    // Frame tracking: open/close state, latched mode and the running word parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_acc   <= 1'b0;
        end else if (w_accept) begin
            r_acc  <= w_acc_nxt;
            r_mode <= w_mode;
            case (r_state)
                S_IDLE:  r_state <= in_last ? S_IDLE : S_FRAME;
                S_FRAME: r_state <= in_last ? S_IDLE : S_FRAME;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output slot: load on accept, otherwise empty out once downstream takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_par   <= 1'b0;
            r_out_last  <= 1'b0;
            r_frame_par <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_par   <= w_wp ^ w_mode;
            r_out_last  <= in_last;
            r_frame_par <= in_last ? w_fpar : 1'b0;
            r_err       <= w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Error counter: saturates at all-ones; a clear that lands on an error leaves 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= w_inc ? CNT_W'(1) : '0;
        end else if (w_inc && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_par   = r_out_par;
    assign out_last  = r_out_last;
    assign frame_par = r_frame_par;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_parity_stream.sv
// tb_parity_stream: the stimulus is partly directed and partly random. A
// beat-level reference model computes parity by counting ones over the whole
// frame. The bench compares two DUTs against that model on every cycle: one
// DUT uses the default counter width and the other uses a 2-bit counter.
module tb_parity_stream;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic odd_mode, in_valid, in_last, in_par, err_clr, out_ready;
    logic [W-1:0] in_data;

    logic         a_in_ready, a_out_valid, a_out_par, a_out_last, a_frame_par, a_err;
    logic [W-1:0] a_out_data;
    logic [7:0]   a_err_cnt;
    logic         b_in_ready, b_out_valid, b_out_par, b_out_last, b_frame_par, b_err;
    logic [W-1:0] b_out_data;
    logic [1:0]   b_err_cnt;

    int n_chk = 0;
    int n_err = 0;
    int p_ready = 100;

    always #5 clk = ~clk;

    parity_stream #(.WIDTH(W), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last), .in_par(in_par),
        .err_clr(err_clr), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_par(a_out_par), .out_last(a_out_last),
        .frame_par(a_frame_par), .err(a_err), .err_cnt(a_err_cnt));

    parity_stream #(.WIDTH(W), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last), .in_par(in_par),
        .err_clr(err_clr), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_par(b_out_par), .out_last(b_out_last),
        .frame_par(b_frame_par), .err(b_err), .err_cnt(b_err_cnt));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (beat level) ----------------
    logic         m_valid, m_par, m_last, m_fp, m_err, m_mode;
    logic [W-1:0] m_data;
    logic [W-1:0] m_fbuf [0:15];
    int           m_fcnt;
    int           m_cnt_a, m_cnt_b;

    logic m_acc, m_mode_now, m_wpar, m_fp_now, m_bad;
    int   m_ones;

    // Parity of a frame = parity of the total number of one bits it contains.
    always_comb begin
        m_acc      = in_valid && (!m_valid || out_ready);
        m_mode_now = (m_fcnt == 0) ? odd_mode : m_mode;
        m_wpar     = ($countones(in_data) % 2 == 1) ^ m_mode_now;
        m_ones     = $countones(in_data);
        for (int k = 0; k < 16; k++)
            if (k < m_fcnt) m_ones = m_ones + $countones(m_fbuf[k]);
        m_fp_now   = (m_ones % 2 == 1) ^ m_mode_now;
        m_bad      = in_last && (in_par != m_fp_now);
    end

    function automatic int cnt_next(input int cur, input int max, input bit inc, input bit clr);
        if (clr) return inc ? 1 : 0;
        if (inc) return (cur < max) ? cur + 1 : max;
        return cur;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_data <= '0; m_par <= 1'b0; m_last <= 1'b0;
            m_fp <= 1'b0; m_err <= 1'b0; m_mode <= 1'b0; m_fcnt <= 0;
            m_cnt_a <= 0; m_cnt_b <= 0;
        end else begin
            m_cnt_a <= cnt_next(m_cnt_a, 255, m_acc && m_bad, err_clr);
            m_cnt_b <= cnt_next(m_cnt_b, 3,   m_acc && m_bad, err_clr);
            if (m_acc) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
                m_par   <= m_wpar;
                m_last  <= in_last;
                m_fp    <= in_last ? m_fp_now : 1'b0;
                m_err   <= m_bad;
                if (m_fcnt == 0) m_mode <= odd_mode;
                if (in_last) m_fcnt <= 0;
                else begin
                    m_fbuf[m_fcnt] <= in_data;
                    m_fcnt <= m_fcnt + 1;
                end
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        chk("a_in_ready", a_in_ready, !m_valid || out_ready);
        chk("b_in_ready", b_in_ready, !m_valid || out_ready);
        chk("a_out_valid", a_out_valid, m_valid);
        chk("b_out_valid", b_out_valid, m_valid);
        chk("a_err_cnt", a_err_cnt, m_cnt_a);
        chk("b_err_cnt", b_err_cnt, m_cnt_b);
        if (m_valid) begin
            chk("a_out_data", a_out_data, m_data);
            chk("b_out_data", b_out_data, m_data);
            chk("a_out_par", a_out_par, m_par);
            chk("b_out_par", b_out_par, m_par);
            chk("a_out_last", a_out_last, m_last);
            chk("b_out_last", b_out_last, m_last);
            chk("a_frame_par", a_frame_par, m_fp);
            chk("b_frame_par", b_frame_par, m_fp);
            chk("a_err", a_err, m_err);
            chk("b_err", b_err, m_err);
        end
    end

    // ---------------- drivers ----------------
    // Present one beat and hold it until accepted; return at the next negedge + 2.
    task automatic send(input logic [W-1:0] d, input bit last, input bit par, input bit mode);
        bit rdy;
        int guard = 0;
        in_valid = 1'b1; in_data = d; in_last = last; in_par = par; odd_mode = mode;
        forever begin
            out_ready = ($urandom_range(99) < p_ready);
            #1;
            rdy = a_in_ready;
            @(posedge clk);
            @(negedge clk); #2;
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            odd_mode = $urandom_range(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            out_ready = ($urandom_range(99) < p_ready);
            @(posedge clk);
            @(negedge clk); #2;
        end
    endtask

    initial begin
        rst_n = 1'b0; odd_mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_par = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_outs_a", {a_out_data, a_out_par, a_out_last, a_frame_par, a_err, a_err_cnt}, 0);
        chk("rst_outs_b", {b_out_data, b_out_par, b_out_last, b_frame_par, b_err, b_err_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk); #2;

        // Even single beat.
        send(8'h07, 1, 1, 0);
        chk("r040_valid", a_out_valid, 1);
        chk("r040_par", a_out_par, 1);
        chk("r040_fp", a_frame_par, 1);
        chk("r040_err", a_err, 0);
        chk("r040_cnt", a_err_cnt, 0);

        // Odd single beat with a wrong parity bit.
        send(8'h03, 1, 0, 1);
        chk("r041_par", a_out_par, 1);
        chk("r041_fp", a_frame_par, 1);
        chk("r041_err", a_err, 1);
        chk("r041_cnt", a_err_cnt, 1);

        // Three-beat even frame; the mode toggle inside the frame is ignored.
        send(8'h01, 0, 0, 0);
        chk("r042_par1", a_out_par, 1);
        chk("r042_fp1", a_frame_par, 0);
        send(8'h03, 0, 0, 1);
        chk("r042_par2", a_out_par, 0);
        send(8'h07, 1, 0, 1);
        chk("r042_par3", a_out_par, 1);
        chk("r042_fp3", a_frame_par, 0);
        chk("r042_err3", a_err, 0);

        // Backpressure with the slot full and a new beat waiting.
        in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b1; in_par = 1'b0; odd_mode = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("r043_in_ready", a_in_ready, 0);
            chk("r043_hold_data", a_out_data, 8'h07);
            chk("r043_hold_fp", a_frame_par, 0);
            @(posedge clk);
            @(negedge clk); #2;
        end
        send(8'hA5, 1, 0, 0);
        chk("r043_data1", a_out_data, 8'hA5);
        send(8'h5A, 1, 0, 0);
        chk("r043_data2", a_out_data, 8'h5A);

        // Saturation of the 2-bit counter and a clear that coincides with an error.
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        chk("r044_clr", a_err_cnt, 0);
        repeat (5) send(8'h00, 1, 1, 0);
        chk("r044_sat_b", b_err_cnt, 3);
        chk("r044_cnt_a", a_err_cnt, 5);
        err_clr = 1'b1;
        send(8'h00, 1, 1, 0);
        err_clr = 1'b0;
        chk("r044_clrinc_b", b_err_cnt, 1);
        chk("r044_clrinc_a", a_err_cnt, 1);
        idle(1);
        chk("r025_drain", a_out_valid, 0);

        // Reset mid-frame discards the open frame.
        send(8'h01, 0, 0, 0);
        send(8'h01, 0, 0, 0);
        rst_n = 1'b0; #1;
        chk("r045_rst_valid", a_out_valid, 0);
        chk("r045_rst_ready", a_in_ready, 1);
        @(negedge clk); #2; rst_n = 1'b1;
        send(8'h01, 1, 1, 0);
        chk("r045_fp", a_frame_par, 1);
        chk("r045_err", a_err, 0);
        send(8'h01, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk); #2; rst_n = 1'b1;
        send(8'h00, 1, 0, 0);
        chk("r039_fp", a_frame_par, 0);
        chk("r039_err", a_err, 0);

        // Random frames under random backpressure.
        p_ready = 60;
        for (int f = 0; f < 400; f++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int bt = 0; bt < len; bt++) begin
                err_clr = ($urandom_range(99) < 5);
                send(W'($urandom), bt == len - 1, $urandom_range(1), $urandom_range(1));
                err_clr = 1'b0;
                if ($urandom_range(3) == 0) idle($urandom_range(1, 2));
            end
        end
        p_ready = 100;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
